// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: frames VECTOR_LENGTH-beat tiles and skews lane r by 1+r cycles onto the array edge
// Ports: clk, rst (sync, active high); in_data/in_valid/in_ready operand beat handshake;
// lane_data/lane_valid skewed edge operands; pe_clear tile-start clear; busy not idle; tile_done last beat out.
`ifndef SYSTOLIC_INPUT_WIDTH
`define SYSTOLIC_INPUT_WIDTH 16
`endif
module systolic_skew_feeder #(
    parameter int INPUT_WIDTH   = `SYSTOLIC_INPUT_WIDTH,
    parameter int LANES         = 4,
    parameter int VECTOR_LENGTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES*INPUT_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [LANES*INPUT_WIDTH-1:0] lane_data,
    output logic [LANES-1:0]             lane_valid,
    output logic                         pe_clear,
    output logic                         busy,
    output logic                         tile_done
);
    localparam int CW = $clog2(VECTOR_LENGTH + 1);
    localparam int DW = $clog2(LANES + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dcnt;
    logic          acc;
    logic          fin;

    assign in_ready = state == STREAM;
    assign acc      = in_valid & in_ready;
    assign fin      = acc && int'(cnt) == VECTOR_LENGTH - 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dcnt      <= '0;
            pe_clear  <= 1'b0;
            busy      <= 1'b0;
            tile_done <= 1'b0;
        end else begin
            pe_clear  <= state == IDLE && in_valid;
            // the last skewed beat reaches lane LANES-1 exactly LANES cycles after its acceptance
            tile_done <= LANES == 1 ? fin : state == DRAIN && int'(dcnt) == LANES - 2;
            case (state)
                IDLE: if (in_valid) begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
                CLEAR: begin
                    state <= STREAM;
                    cnt   <= '0;
                end
                STREAM: if (acc) begin
                    cnt <= cnt + 1'b1;
                    if (fin) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end
                end
                DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (int'(dcnt) == LANES - 1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < LANES; r++) begin : g_lane
        logic [INPUT_WIDTH-1:0] d [r+1];
        logic [r:0]             v;
        always_ff @(posedge clk) begin
            if (rst) begin
                v <= '0;
                for (int k = 0; k <= r; k++) d[k] <= '0;
            end else begin
                v    <= (v << 1) | (r+1)'(acc);
                // zero data enters with every bubble, so downstream stages stay zero wherever valid is low
                d[0] <= acc ? in_data[r*INPUT_WIDTH +: INPUT_WIDTH] : '0;
                for (int k = 1; k <= r; k++) d[k] <= d[k-1];
            end
        end
        assign lane_data[r*INPUT_WIDTH +: INPUT_WIDTH] = d[r];
        assign lane_valid[r]                           = v[r];
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: table, directed and randomized checks of the skew feeder against a tile-level model
module tb_systolic_skew_feeder;
    localparam int W  = 16;
    localparam int L  = 4;
    localparam int VL = 4;
    localparam int NC = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [L*W-1:0] in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [L*W-1:0] lane_data;
    logic [L-1:0]   lane_valid;
    logic           pe_clear;
    logic           busy;
    logic           tile_done;

    int total = 0;
    int bad   = 0;

    systolic_skew_feeder #(.INPUT_WIDTH(W), .LANES(L), .VECTOR_LENGTH(VL)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .lane_data(lane_data), .lane_valid(lane_valid), .pe_clear(pe_clear), .busy(busy),
        .tile_done(tile_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           iv;
        logic [L*W-1:0] din;
        logic [L-1:0]   lv;
        logic [L*W-1:0] ld;
        logic           clr;
        logic           done;
        logic           bsy;
        logic           rdy;
    } row_t;

    row_t tbl [10];

    logic           vv    [NC];
    logic [L*W-1:0] vd    [NC];
    logic           acc_m [NC];
    logic [L-1:0]   e_lv  [NC];
    logic [L*W-1:0] e_ld  [NC];
    logic           e_clr [NC];
    logic           e_done[NC];
    logic           e_busy[NC];
    logic           e_rdy [NC];

    function automatic logic [L*W-1:0] v4(int a, int b, int c, int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [W-1:0] ext(int i);
        case (i)
            0:       return 16'h8000;
            1:       return 16'h7fff;
            2:       return 16'hffff;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [L*W-1:0] rnd_vec(int mode);
        logic [L*W-1:0] v;
        for (int r = 0; r < L; r++)
            v[r*W +: W] = mode == 1 ? ext(r) : ($urandom_range(0, 3) == 0 ? ext($urandom_range(0, 3)) : W'($urandom));
        return v;
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int n, input logic [L-1:0] lv, input logic [L*W-1:0] ld,
                           input logic clr, input logic done, input logic bsy, input logic rdy);
        chk({tag, ".lane_valid"}, n, 64'(lane_valid), 64'(lv));
        chk({tag, ".lane_data"},  n, 64'(lane_data),  64'(ld));
        chk({tag, ".pe_clear"},   n, 64'(pe_clear),   64'(clr));
        chk({tag, ".tile_done"},  n, 64'(tile_done),  64'(done));
        chk({tag, ".busy"},       n, 64'(busy),       64'(bsy));
        chk({tag, ".in_ready"},   n, 64'(in_ready),   64'(rdy));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Tile-level model: index n means "just after the n-th edge following reset".
    // A tile opens at the first valid edge s once idle, clears after s, accepts from edge s+2,
    // presents beat a on lane r after edge a+r, and is done LANES-1 edges after its last beat.
    task automatic build_model(input int mode);
        int from = 0;
        for (int n = 0; n < NC; n++) begin
            acc_m[n] = 0; e_lv[n] = '0; e_ld[n] = '0;
            e_clr[n] = 0; e_done[n] = 0; e_busy[n] = 0; e_rdy[n] = 0;
        end
        while (from < NC) begin
            int s = -1;
            int k = 0;
            int last = -1;
            for (int n = from; n < NC; n++) if (vv[n] && s < 0) s = n;
            if (s < 0) break;
            e_clr[s] = 1;
            for (int n = s + 2; n < NC; n++)
                if (vv[n] && k < VL) begin
                    acc_m[n] = 1;
                    k++;
                    last = n;
                end
            if (k < VL) begin
                for (int n = s; n < NC; n++) e_busy[n] = 1;
                for (int n = s + 1; n < NC; n++) e_rdy[n] = 1;
                break;
            end
            for (int n = s; n < NC && n <= last + L - 1; n++) e_busy[n] = 1;
            for (int n = s + 1; n < last; n++) e_rdy[n] = 1;
            if (last + L - 1 < NC) e_done[last + L - 1] = 1;
            from = last + L + 1;
        end
        // data is held while a valid beat waits, otherwise fresh
        for (int n = 0; n < NC; n++)
            vd[n] = (n > 0 && vv[n] && vv[n-1] && !acc_m[n-1]) ? vd[n-1] : rnd_vec(mode);
        for (int n = 0; n < NC; n++)
            if (acc_m[n])
                for (int r = 0; r < L; r++)
                    if (n + r < NC) begin
                        e_lv[n+r][r]         = 1'b1;
                        e_ld[n+r][r*W +: W]  = vd[n][r*W +: W];
                    end
    endtask

    task automatic run_scn(input string nm, input int mode);
        build_model(mode);
        for (int n = 0; n < NC; n++) begin
            in_valid = vv[n];
            in_data  = vd[n];
            @(posedge clk);
            #1 chk_all(nm, n, e_lv[n], e_ld[n], e_clr[n], e_done[n], e_busy[n], e_rdy[n]);
        end
        do_reset();
    endtask

    task automatic run_tbl(input string nm);
        for (int i = 0; i < 10; i++) begin
            in_valid = tbl[i].iv;
            in_data  = tbl[i].din;
            @(posedge clk);
            #1 chk_all(nm, i, tbl[i].lv, tbl[i].ld, tbl[i].clr, tbl[i].done, tbl[i].bsy, tbl[i].rdy);
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, v4(1, 2, 3, 4),     4'b0000, v4(0, 0, 0, 0),    1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, v4(1, 2, 3, 4),     4'b0000, v4(0, 0, 0, 0),    1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b1, v4(1, 2, 3, 4),     4'b0001, v4(1, 0, 0, 0),    1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, v4(5, 6, 7, 8),     4'b0011, v4(5, 2, 0, 0),    1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b1, v4(9, 10, 11, 12),  4'b0111, v4(9, 6, 3, 0),    1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, v4(13, 14, 15, 16), 4'b1111, v4(13, 10, 7, 4),  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, v4(0, 0, 0, 0),     4'b1110, v4(0, 14, 11, 8),  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, v4(0, 0, 0, 0),     4'b1100, v4(0, 0, 15, 12),  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, v4(0, 0, 0, 0),     4'b1000, v4(0, 0, 0, 16),   1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9] = '{1'b0, v4(0, 0, 0, 0),     4'b0000, v4(0, 0, 0, 0),    1'b0, 1'b0, 1'b0, 1'b0};

        do_reset();
        chk_all("reset", -1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_tbl("basic");

        // mid-tile reset after beat 2
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = i < 3 ? v4(1, 2, 3, 4) : v4(5, 6, 7, 8);
            @(posedge clk);
        end
        #1 rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_all("midrst", 0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 9; i++) begin
            @(posedge clk);
            #1 chk_all("midrst", i, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        run_tbl("after_rst");
        do_reset();

        for (int n = 0; n < NC; n++) vv[n] = n < 4 || n == 6 || n == 7;
        run_scn("gapped", 0);
        for (int n = 0; n < NC; n++) vv[n] = 1'b1;
        run_scn("b2b", 0);
        for (int n = 0; n < NC; n++) vv[n] = n < 12;
        run_scn("extremes", 1);
        for (int t = 0; t < 8; t++) begin
            for (int n = 0; n < NC; n++) vv[n] = $urandom_range(0, 3) != 0;
            run_scn("random", 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
